// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared FSM encoding, BCD digit width and DIGITS sizing helper
// Revision : 1.0
// ============================================================================
package div_pkg;

  localparam int c_bcd_w = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Smallest digit count whose decimal range covers 2^width-1.
  function automatic int min_digits(input int width);
    int     digits;
    longint limit;
    longint max_val;
    digits  = 1;
    limit   = 10;
    max_val = (longint'(1) << width) - 1;
    while (limit <= max_val) begin
      digits++;
      limit *= 10;
    end
    return digits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// ============================================================================
// Module   : bcd_dabble_step
// Brief    : One double-dabble iteration: add-3 on digits >=5, shift in a bit
// Revision : 1.0
// ============================================================================
module bcd_dabble_step
  import div_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [c_bcd_w*DIGITS-1:0] i_acc,
  input  logic                      i_bit,
  output logic [c_bcd_w*DIGITS-1:0] o_acc
);

  logic [c_bcd_w*DIGITS-1:0] w_adj;
  logic                      w_unused_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [c_bcd_w-1:0] w_dig;
    assign w_dig = i_acc[g*c_bcd_w +: c_bcd_w];
    assign w_adj[g*c_bcd_w +: c_bcd_w] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
  end

  // Top bit is always zero when DIGITS is sized for the source range.
  assign w_unused_msb = w_adj[c_bcd_w*DIGITS-1];
  assign o_acc        = {w_adj[c_bcd_w*DIGITS-2:0], i_bit};

endmodule
`default_nettype wire

// File: rtl/div_result_bcd.sv
`default_nettype none
// ============================================================================
// Module   : div_result_bcd
// Brief    : Checks divider quotient, derives remainder, converts both to BCD
// Revision : 1.0
// ============================================================================
module div_result_bcd
  import div_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          dividend,
  input  logic [WIDTH-1:0]          divisor,
  input  logic [WIDTH-1:0]          quotient,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [c_bcd_w*DIGITS-1:0] q_bcd,
  output logic [c_bcd_w*DIGITS-1:0] r_bcd,
  output logic                      div_zero,
  output logic                      chk_err
);

  localparam int c_pw    = 2 * WIDTH;
  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam int c_bw    = c_bcd_w * DIGITS;

  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("div_result_bcd: WIDTH must be in 2..8");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("div_result_bcd: DIGITS too small for WIDTH");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_qsrc;
  logic [WIDTH-1:0]   r_rsrc;
  logic [c_bw-1:0]    r_qacc;
  logic [c_bw-1:0]    r_racc;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_dz;
  logic               r_err;
  logic [c_bw-1:0]    r_q_bcd;
  logic [c_bw-1:0]    r_r_bcd;
  logic               r_div_zero;
  logic               r_chk_err;

  logic [c_pw-1:0]    w_prod;
  logic [c_pw:0]      w_rem;
  logic               w_dz;
  logic               w_err;
  logic [c_bw-1:0]    w_qacc_nxt;
  logic [c_bw-1:0]    w_racc_nxt;

  // Remainder carried in 2*WIDTH+1 bits; the MSB is the sign of the difference.
  assign w_prod = c_pw'(r_quotient) * c_pw'(r_divisor);
  assign w_rem  = {{(WIDTH + 1){1'b0}}, r_dividend} - {1'b0, w_prod};
  assign w_dz   = (r_divisor == '0);
  assign w_err  = !w_dz && (w_rem[c_pw] || (w_rem[c_pw-1:0] >= {{WIDTH{1'b0}}, r_divisor}));

  bcd_dabble_step #(.DIGITS(DIGITS)) u_q_step (
    .i_acc (r_qacc),
    .i_bit (r_qsrc[WIDTH-1]),
    .o_acc (w_qacc_nxt)
  );

  bcd_dabble_step #(.DIGITS(DIGITS)) u_r_step (
    .i_acc (r_racc),
    .i_bit (r_rsrc[WIDTH-1]),
    .o_acc (w_racc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)               w_state_nxt = ST_CHECK;
      ST_CHECK:                             w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == c_cnt_w'(1))   w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)              w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quotient <= '0;
      r_qsrc     <= '0;
      r_rsrc     <= '0;
      r_qacc     <= '0;
      r_racc     <= '0;
      r_cnt      <= '0;
      r_dz       <= 1'b0;
      r_err      <= 1'b0;
      r_q_bcd    <= '0;
      r_r_bcd    <= '0;
      r_div_zero <= 1'b0;
      r_chk_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_quotient <= quotient;
          end
        end
        ST_CHECK: begin
          r_dz   <= w_dz;
          r_err  <= w_err;
          r_qsrc <= w_dz ? '0 : r_quotient;
          r_rsrc <= w_dz ? r_dividend : (w_err ? '0 : w_rem[WIDTH-1:0]);
          r_qacc <= '0;
          r_racc <= '0;
          r_cnt  <= c_cnt_w'(WIDTH);
        end
        ST_SHIFT: begin
          r_qacc <= w_qacc_nxt;
          r_racc <= w_racc_nxt;
          r_qsrc <= {r_qsrc[WIDTH-2:0], 1'b0};
          r_rsrc <= {r_rsrc[WIDTH-2:0], 1'b0};
          r_cnt  <= r_cnt - c_cnt_w'(1);
          // Results are published only on the final shift and then held.
          if (r_cnt == c_cnt_w'(1)) begin
            r_q_bcd    <= w_qacc_nxt;
            r_r_bcd    <= w_racc_nxt;
            r_div_zero <= r_dz;
            r_chk_err  <= r_err;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign q_bcd     = r_q_bcd;
  assign r_bcd     = r_r_bcd;
  assign div_zero  = r_div_zero;
  assign chk_err   = r_chk_err;

endmodule
`default_nettype wire

// File: tb/tb_div_result_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_result_bcd
// Brief    : Self-checking bench for div_result_bcd against a behavioural model
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_div_result_bcd;

  localparam int W = 4;
  localparam int D = 2;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic           in_valid  = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   dividend  = '0;
  logic [W-1:0]   divisor   = '0;
  logic [W-1:0]   quotient  = '0;
  logic           in_ready;
  logic           out_valid;
  logic           div_zero;
  logic           chk_err;
  logic [4*D-1:0] q_bcd;
  logic [4*D-1:0] r_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_result_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd),
    .div_zero  (div_zero),
    .chk_err   (chk_err)
  );

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a result appears W+1 edges after acceptance and is
  // held until the consumer takes it.
  bit             m_idle  = 1'b1;
  bit             m_valid = 1'b0;
  int             m_wait  = 0;
  logic [4*D-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit             m_dz = 1'b0, m_err = 1'b0, p_dz = 1'b0, p_err = 1'b0;
  int             ma, mb, mq, mrem;

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0;
      m_q = '0; m_r = '0; m_dz = 1'b0; m_err = 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        ma    = int'(dividend);
        mb    = int'(divisor);
        mq    = int'(quotient);
        mrem  = ma - mq * mb;
        p_dz  = (mb == 0);
        p_err = !p_dz && (mrem < 0 || mrem >= mb);
        p_q   = to_bcd(p_dz ? 0 : mq);
        p_r   = to_bcd(p_dz ? ma : (p_err ? 0 : mrem));
        m_idle = 1'b0;
        m_wait = W + 1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1;
        m_q = p_q; m_r = p_r; m_dz = p_dz; m_err = p_err;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready",  in_ready,  m_idle);
      check("out_valid", out_valid, m_valid);
      check("q_bcd",     q_bcd,     m_q);
      check("r_bcd",     r_bcd,     m_r);
      check("div_zero",  div_zero,  m_dz);
      check("chk_err",   chk_err,   m_err);
    end
  end

  task automatic txn(input int a, input int b, input int q, input int hold, input bit lit,
                     input logic [7:0] eq, input logic [7:0] er, input bit edz, input bit eerr);
    int n;
    dividend = W'(a); divisor = W'(b); quotient = W'(q); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("latency", n, W + 1);
    if (lit) begin
      check("lit_q_bcd",    q_bcd,    eq);
      check("lit_r_bcd",    r_bcd,    er);
      check("lit_div_zero", div_zero, edz);
      check("lit_chk_err",  chk_err,  eerr);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = W'($urandom); divisor = W'($urandom); quotient = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after_take", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, q;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q_bcd",     q_bcd,     0);
    check("rst_r_bcd",     r_bcd,     0);

    txn(13, 3, 4,  0, 1, 8'h04, 8'h01, 1'b0, 1'b0);
    txn(15, 1, 15, 0, 1, 8'h15, 8'h00, 1'b0, 1'b0);
    txn(14, 5, 2,  1, 1, 8'h02, 8'h04, 1'b0, 1'b0);
    txn(9,  0, 15, 0, 1, 8'h00, 8'h09, 1'b1, 1'b0);
    txn(13, 3, 5,  2, 1, 8'h05, 8'h00, 1'b0, 1'b1);
    txn(13, 3, 3,  0, 1, 8'h03, 8'h00, 1'b0, 1'b1);
    txn(13, 3, 4, 10, 1, 8'h04, 8'h01, 1'b0, 1'b0);

    // Reset asserted while the second shift cycle is in progress.
    dividend = 4'd11; divisor = 4'd2; quotient = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready",  in_ready,  1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_q_bcd",     q_bcd,     0);
    check("midrst_r_bcd",     r_bcd,     0);
    check("midrst_div_zero",  div_zero,  0);
    check("midrst_chk_err",   chk_err,   0);
    txn(7, 2, 3, 0, 1, 8'h03, 8'h01, 1'b0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      q = (b == 0) ? 15 : a / b;
      if ($urandom_range(0, 9) < 3) q = int'($urandom_range(0, 15));
      txn(a, b, q, int'($urandom_range(0, 3)), 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_result_bcd.md
Name: div_result_bcd

Overview:
- Downstream stage of the 4-bit combinational restoring divider: consumes dividend, divisor and quotient, derives and checks the remainder, and converts quotient and remainder to packed BCD for the lab display path.
- Sequential, with a valid/ready handshake on both sides.
- Conversion is iterative double-dabble, one bit per clock.
- Also flags divide-by-zero and a quotient that is inconsistent with its operands.

Parameters:
- WIDTH, 4, operand/quotient width in bits (legal range 2..8).
- DIGITS, 2, BCD digits per result; 10^DIGITS > 2^WIDTH-1 is required (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands and quotient present
- in_ready  output  1  stage can accept
- dividend  input  WIDTH  divider input a
- divisor  input  WIDTH  divider input b
- quotient  input  WIDTH  divider output
- out_valid  output  1  results present
- out_ready  input  1  consumer accepts
- q_bcd  output  4*DIGITS  quotient in packed BCD, digit 0 = bits [3:0]
- r_bcd  output  4*DIGITS  remainder in packed BCD
- div_zero  output  1  divisor was 0
- chk_err  output  1  remainder out of range [0, divisor-1]

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; q_bcd=0; r_bcd=0; div_zero=0; chk_err=0.
  - Applies from any state, including mid-SHIFT or DONE; any in-flight result is discarded.
- FSM states: IDLE, CHECK, SHIFT, DONE.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE.
- IDLE:
  - On in_valid & in_ready, register dividend, divisor and quotient, then go to CHECK.
  - in_valid is ignored in all other states; no skid buffer.
- CHECK (1 cycle):
  - rem = dividend - quotient*divisor, computed signed over 2*WIDTH+1 bits.
  - div_zero = (divisor==0).
  - chk_err = !div_zero & (rem<0 | rem>=divisor).
  - Shift sources:
    - normal: qsrc=quotient, rsrc=rem[WIDTH-1:0]
    - div_zero: qsrc=0, rsrc=dividend
    - chk_err: qsrc=quotient, rsrc=0
  - Clear both BCD accumulators and load bit counter = WIDTH. Go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, on each accumulator: every digit >=5 gets +3, then the whole accumulator shifts left one bit with the source MSB entering bit 0.
  - Each source shifts left one bit; the counter decrements.
  - When the counter reaches 1, the next state is DONE.
- DONE:
  - Hold q_bcd, r_bcd, div_zero and chk_err stable while out_ready is low, for any number of cycles.
  - On out_ready, go to IDLE. in_ready rises the next cycle, so there is no same-cycle re-accept.
- Latency: out_valid goes high WIDTH+1 edges after the accepting edge (5 for WIDTH=4).
- Throughput: one result per WIDTH+3 cycles with out_ready held high.
- Outputs q_bcd, r_bcd, div_zero and chk_err are registers. They update only at the SHIFT→DONE transition and are held through IDLE until the next result.
- Width rules:
  - quotient*divisor is 2*WIDTH bits.
  - rem uses a sign bit; no truncation before the range check.
  - BCD digits never exceed 9.

Decomposition:
- Shared package div_pkg:
  - FSM state enum (2-bit encoding: IDLE=0, CHECK=1, SHIFT=2, DONE=3)
  - constant function for minimum DIGITS given WIDTH
  - BCD digit width constant (4)
- One sub-module, bcd_dabble_step:
  - combinational; inputs: accumulator (4*DIGITS) and the incoming bit; output: the adjusted-and-shifted accumulator.
  - Instantiated twice, once for quotient and once for remainder.

Test Plan:
- 13/3, quotient 4 → after 5 edges out_valid=1; q_bcd=0x04, r_bcd=0x01, div_zero=0, chk_err=0.
- 15/1, quotient 15 → q_bcd=0x15, r_bcd=0x00; also 14/5, quotient 2 → q_bcd=0x02, r_bcd=0x04.
- Divide-by-zero: 9/0, quotient 15 (divider saturates) → div_zero=1, chk_err=0, q_bcd=0x00, r_bcd=0x09.
- Bad quotient:
  - 13/3 with quotient 5 → chk_err=1, q_bcd=0x05, r_bcd=0x00.
  - 13/3 with quotient 3 (rem 4 ≥ 3) → chk_err=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands → outputs stable, in_ready=0, new operands never accepted. Then out_ready=1 → in_ready=1 one cycle later.
- Reset mid-operation: rst=1 during the 2nd SHIFT cycle → next edge: IDLE, in_ready=1, out_valid=0, all outputs 0. A following 7/2, quotient 3 → q_bcd=0x03, r_bcd=0x01 with normal latency.
